// File: rtl/pe_link_pkg.sv
// rtl/pe_link_pkg.sv - shared east/west link framing constants and word layout
package pe_link_pkg;

   localparam int LINK_EAST_WIDTH = 130;
   localparam int LINK_DATA_WIDTH = LINK_EAST_WIDTH - 2;

   localparam int LINK_VALID_BIT  = LINK_EAST_WIDTH - 1;
   localparam int LINK_LAST_BIT   = LINK_EAST_WIDTH - 2;
   localparam int LINK_CREDIT_BIT = 0;

   typedef struct packed {
      logic                       valid;
      logic                       last;
      logic [LINK_DATA_WIDTH-1:0] payload;
   } link_word_t;

endpackage

// File: rtl/pe_link_fifo.sv
// rtl/pe_link_fifo.sv - small synchronous staging FIFO with full/empty/count
module pe_link_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State register; reset discards any queued words
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/pe_link_tx_east.sv
// rtl/pe_link_tx_east.sv - credit-flow-controlled transmit end of the east tile link
module pe_link_tx_east
   import pe_link_pkg::*;
#(
   parameter int EAST_WIDTH = LINK_EAST_WIDTH,
   parameter int DATA_WIDTH = EAST_WIDTH - 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CREDITS    = 8,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ap_start,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [EAST_WIDTH-1:0] in_from_east,
   output logic [EAST_WIDTH-1:0] out_to_east,
   output logic [CNT_W-1:0]      credit_cnt,
   output logic                  err_credit
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH:0]   head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FCW-1:0]        fifo_count_unused;
   logic                  send;
   logic                  credit_pulse;
   logic                  unused_in_bits;

   logic [EAST_WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0]      credit_q, credit_d;
   logic                  err_q, err_d;

   assign credit_pulse   = in_from_east[LINK_CREDIT_BIT];
   assign unused_in_bits = ^in_from_east[EAST_WIDTH-1:1];

   assign s_ready     = !fifo_full;
   assign send        = ap_start && !fifo_empty && (credit_q != '0);
   assign out_to_east = out_q;
   assign credit_cnt  = credit_q;
   assign err_credit  = err_q;

   pe_link_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH),
      .CW    (FCW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (s_valid),
      .wr_data ({s_last, s_data}),
      .pop     (send),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count_unused)
   );

   // Output word: launch the FIFO head on send, otherwise drop valid and hold last/payload
   always_comb begin
      out_d = out_q;
      if (send) begin
         out_d = {1'b1, head};
      end else begin
         out_d[EAST_WIDTH-1] = 1'b0;
      end
   end

   // Credit accounting; a return pulse at full credit saturates and latches the overflow error
   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      case ({send, credit_pulse})
         2'b10: credit_d = credit_q - CNT_W'(1);
         2'b01: begin
            if (credit_q == CNT_W'(CREDITS)) begin
               err_d = 1'b1;
            end else begin
               credit_d = credit_q + CNT_W'(1);
            end
         end
         default: credit_d = credit_q;
      endcase
   end

   // Link output, credit and error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q    <= '0;
         credit_q <= CNT_W'(CREDITS);
         err_q    <= 1'b0;
      end else begin
         out_q    <= out_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_pe_link_tx_east.sv
// tb/tb_pe_link_tx_east.sv - randomized self-checking bench for pe_link_tx_east
module tb_pe_link_tx_east;

   localparam int EW = 130;
   localparam int DW = 128;
   localparam int FD = 4;
   localparam int CR = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          ap_start;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          s_valid;
   logic          s_ready;
   logic [EW-1:0] in_from_east;
   logic [EW-1:0] out_to_east;
   logic [3:0]    credit_cnt;
   logic          err_credit;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW:0]   mq [$];
   int            m_cred;
   bit            m_err;
   logic          m_valid;
   logic          m_last;
   logic [DW-1:0] m_data;

   pe_link_tx_east dut (
      .clk          (clk),
      .reset        (reset),
      .ap_start     (ap_start),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .in_from_east (in_from_east),
      .out_to_east  (out_to_east),
      .credit_cnt   (credit_cnt),
      .err_credit   (err_credit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_cred  = CR;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = '0;
   endtask

   // One clock edge: the model applies the link rules to the inputs present before the edge
   task automatic step();
      bit acc, snd, pls;
      acc = s_valid && (mq.size() < FD);
      snd = ap_start && (mq.size() > 0) && (m_cred > 0);
      pls = in_from_east[0];
      @(posedge clk);
      #1;
      if (snd) begin
         {m_last, m_data} = mq.pop_front();
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (snd && !pls) m_cred--;
      else if (pls && !snd) begin
         if (m_cred == CR) m_err = 1'b1;
         else m_cred++;
      end
      if (acc) mq.push_back({s_last, s_data});
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},   out_to_east, {m_valid, m_last, m_data});
      check({tag, ".cred"},  EW'(credit_cnt), EW'(m_cred));
      check({tag, ".ready"}, EW'(s_ready), EW'(mq.size() < FD));
      check({tag, ".err"},   EW'(err_credit), EW'(m_err));
   endtask

   task automatic set_in(input bit v, input bit l, input logic [DW-1:0] d, input bit ap, input bit p);
      s_valid      = v;
      s_last       = l;
      s_data       = d;
      ap_start     = ap;
      in_from_east = {{(EW-1){1'b0}}, p};
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int pushed;
      int sends;
      int guard;
      logic [DW:0] held [3];

      reset = 1'b1;
      set_in(0, 0, '0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      check("rst.out",   out_to_east, '0);
      check("rst.cred",  EW'(credit_cnt), EW'(8));
      check("rst.ready", EW'(s_ready), EW'(1));
      check("rst.err",   EW'(err_credit), EW'(0));

      // single word
      set_in(1, 1, 128'hA5, 1, 0);
      step();
      set_in(0, 0, '0, 1, 0);
      step();
      check("single.word", out_to_east, {2'b11, 128'hA5});
      check("single.cred", EW'(credit_cnt), EW'(7));
      check_all("single");
      step();
      check("single.drop", EW'(out_to_east[EW-1]), EW'(0));
      set_in(0, 0, '0, 1, 1);
      step();
      set_in(0, 0, '0, 1, 0);
      step();
      check_all("restore");

      // credit exhaustion with 12 back-to-back words
      pushed = 0;
      sends  = 0;
      guard  = 0;
      while (pushed < 12 && guard < 40) begin
         set_in(1, pushed[0], DW'(pushed + 100), 1, 0);
         if (mq.size() < FD) pushed++;
         step();
         if (out_to_east[EW-1]) sends++;
         check_all("exh");
         guard++;
      end
      check("exh.pushed", EW'(pushed), EW'(12));
      set_in(0, 0, '0, 1, 0);
      repeat (4) begin
         step();
         if (out_to_east[EW-1]) sends++;
      end
      check("exh.sends", EW'(sends), EW'(8));
      check("exh.cred0", EW'(credit_cnt), EW'(0));
      check("exh.full",  EW'(s_ready), EW'(0));
      check_all("exh.end");
      set_in(0, 0, '0, 1, 1);
      step();
      sends = 0;
      set_in(0, 0, '0, 1, 0);
      repeat (4) begin
         step();
         if (out_to_east[EW-1]) sends++;
         check_all("onecred");
      end
      check("onecred.sends", EW'(sends), EW'(1));

      // bring credit to 5 with ap_start low, then send while a credit returns
      set_in(0, 0, '0, 0, 1);
      repeat (5) step();
      check("sim.pre", EW'(credit_cnt), EW'(5));
      set_in(0, 0, '0, 1, 1);
      step();
      check("sim.cred5", EW'(credit_cnt), EW'(5));
      check_all("sim");
      set_in(0, 0, '0, 1, 0);
      repeat (3) step();
      check_all("drain");

      // overflow while gated, words held until ap_start rises
      set_in(0, 0, '0, 0, 1);
      repeat (5) step();
      check("ovf.pre", EW'(credit_cnt), EW'(8));
      for (int k = 0; k < 3; k++) begin
         held[k] = {k[0], rand_data()};
         set_in(1, held[k][DW], held[k][DW-1:0], 0, k == 0);
         step();
         check_all("gated");
      end
      check("ovf.err",  EW'(err_credit), EW'(1));
      check("ovf.cred", EW'(credit_cnt), EW'(8));
      set_in(0, 0, '0, 0, 0);
      step();
      check("gated.novalid", EW'(out_to_east[EW-1]), EW'(0));
      set_in(0, 0, '0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("drain.order", out_to_east, {1'b1, held[k]});
      end
      step();
      check_all("drain.end");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), rand_data(),
                $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0);
         step();
         check_all("rand");
      end

      // reset mid-stream with words queued and a word on the link
      set_in(0, 0, '0, 0, 1);
      repeat (8) step();
      for (int k = 0; k < 4; k++) begin
         set_in(1, 0, rand_data(), 0, 0);
         step();
      end
      set_in(0, 0, '0, 1, 0);
      step();
      check("mid.valid", EW'(out_to_east[EW-1]), EW'(1));
      check("mid.queued", EW'(mq.size()), EW'(3));
      #2 reset = 1'b1;
      #1;
      check("mid.clear", out_to_east, '0);
      set_in(0, 0, '0, 1, 0);
      @(posedge clk);
      #3 reset = 1'b0;
      model_reset();
      check("post.cred",  EW'(credit_cnt), EW'(8));
      check("post.ready", EW'(s_ready), EW'(1));
      check("post.err",   EW'(err_credit), EW'(0));
      sends = 0;
      repeat (8) begin
         step();
         if (out_to_east[EW-1]) sends++;
         check_all("post");
      end
      check("post.nostale", EW'(sends), EW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
